// File: rtl/mem_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states, word-index sizing.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_WRITE   = 3'd3,
    ST_DONE    = 3'd4
  } lsu_state_e;

  localparam int WORD_LSB = 2;

  function automatic int word_idx_w(input int addr_width);
    return addr_width - WORD_LSB;
  endfunction

  // Stores only have B/H/W; loads additionally have BU/HU.
  function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
    if (is_store) return (f3 > F3_W);
    return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
  endfunction

endpackage

// File: rtl/load_extend.sv
// Byte/half lane selection and sign/zero extension of a loaded RAM word (combinational).
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (off_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
    // Half offsets use addr[1] only, which also truncates a misaligned half.
    half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];

    case (funct3_i)
      F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data_o = {24'd0, byte_sel};
      F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data_o = {16'd0, half_sel};
      F3_W:    data_o = word_i;
      default: data_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between execute stage and a 1-cycle registered word RAM; RMW for SB/SH.
// Optional LSU_MISALIGN_TRAP_EN: misaligned H/W accesses error instead of being truncated.
module load_store_unit
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_error,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [31:0]           ram_data_in,
  output logic                  ram_write_enable,
  input  logic [31:0]           ram_data_out
);

  localparam int IDXW = word_idx_w(ADDR_WIDTH);

  lsu_state_e            state_q;
  logic                  write_q;
  logic [2:0]            f3_q;
  logic [1:0]            off_q;
  logic [15:0]           wdata_q;
  logic                  resp_valid_q;
  logic                  resp_error_q;
  logic [31:0]           resp_rdata_q;
  logic [ADDR_WIDTH-1:0] ram_address_q;
  logic [31:0]           ram_data_in_q;
  logic                  ram_we_q;

  logic                  misalign_d;
  logic                  req_err_d;
  logic [31:0]           merge_d;
  logic [31:0]           load_data_d;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_d = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));
`else
  assign misalign_d = 1'b0;
`endif

  assign req_err_d = f3_illegal(req_write, req_funct3) || misalign_d;
  assign req_ready = (state_q == ST_IDLE);

  load_extend u_load_extend (
    .word_i   (ram_data_out),
    .off_i    (off_q),
    .funct3_i (f3_q),
    .data_o   (load_data_d)
  );

  // Sub-word store merge; f3_q here is only ever SB or SH.
  always_comb begin
    merge_d = ram_data_out;
    if (f3_q == F3_H) begin
      if (off_q[1]) merge_d[31:16] = wdata_q;
      else          merge_d[15:0]  = wdata_q;
    end else begin
      case (off_q)
        2'd0:    merge_d[7:0]   = wdata_q[7:0];
        2'd1:    merge_d[15:8]  = wdata_q[7:0];
        2'd2:    merge_d[23:16] = wdata_q[7:0];
        default: merge_d[31:24] = wdata_q[7:0];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      write_q       <= 1'b0;
      f3_q          <= 3'd0;
      off_q         <= 2'd0;
      wdata_q       <= 16'd0;
      resp_valid_q  <= 1'b0;
      resp_error_q  <= 1'b0;
      resp_rdata_q  <= 32'd0;
      ram_address_q <= '0;
      ram_data_in_q <= 32'd0;
      ram_we_q      <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      ram_we_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            write_q <= req_write;
            f3_q    <= req_funct3;
            off_q   <= req_addr[1:0];
            wdata_q <= req_wdata[15:0];
            if (req_err_d) begin
              state_q      <= ST_DONE;
              resp_valid_q <= 1'b1;
              resp_error_q <= 1'b1;
              resp_rdata_q <= 32'd0;
            end else begin
              ram_address_q <= {req_addr[ADDR_WIDTH-1:WORD_LSB], 2'b00};
              if (req_write && (req_funct3 == F3_W)) begin
                state_q       <= ST_WRITE;
                ram_data_in_q <= req_wdata;
                ram_we_q      <= 1'b1;
              end else begin
                state_q <= ST_READ;
              end
            end
          end
        end
        ST_READ: state_q <= ST_CAPTURE;
        ST_CAPTURE: begin
          if (write_q) begin
            state_q       <= ST_WRITE;
            ram_data_in_q <= merge_d;
            ram_we_q      <= 1'b1;
          end else begin
            state_q      <= ST_DONE;
            resp_valid_q <= 1'b1;
            resp_error_q <= 1'b0;
            resp_rdata_q <= load_data_d;
          end
        end
        ST_WRITE: begin
          state_q      <= ST_DONE;
          resp_valid_q <= 1'b1;
          resp_error_q <= 1'b0;
          resp_rdata_q <= 32'd0;
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign resp_valid       = resp_valid_q;
  assign resp_error       = resp_error_q;
  assign resp_rdata       = resp_rdata_q;
  assign ram_address      = ram_address_q;
  assign ram_data_in      = ram_data_in_q;
  assign ram_write_enable = ram_we_q;

  logic [IDXW-1:0] unused_idx;
  assign unused_idx = ram_address_q[ADDR_WIDTH-1:WORD_LSB];

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator-side memory access unit between the core's execute stage and the word-addressed data RAM.
- Accepts RISC-V load/store requests: LB/LH/LW/LBU/LHU, SB/SH/SW.
- Drives the RAM's address, data and write-enable port, and captures RAM read data with its fixed 1-cycle registered latency.
- Performs byte-lane extraction and sign/zero extension for loads, and read-modify-write for sub-word stores.

Parameters:
- ADDR_WIDTH, 32: width of req_addr and ram_address. The RAM word index is address[ADDR_WIDTH-1:2].

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 (size and signedness).
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  store data; low bits are used for SB/SH.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_error  out  1  valid with resp_valid; illegal funct3 or misaligned access.
- ram_address  out  ADDR_WIDTH  RAM byte address; always word-aligned (low 2 bits 0).
- ram_data_in  out  32  RAM write data.
- ram_write_enable  out  1  RAM write strobe.
- ram_data_out  in  32  RAM read data, valid the cycle after the address is presented.

Behaviour:
- Reset, synchronous, any state:
  - state becomes IDLE; any in-flight transaction is dropped, with no resp_valid and no further RAM write.
  - resp_valid=0, resp_error=0, resp_rdata=0, ram_address=0, ram_data_in=0, ram_write_enable=0.
  - req_ready=1 in the first cycle after reset.
- All outputs are registered, except req_ready, which is decoded from state.
- Handshake:
  - A request is accepted on a posedge with req_valid && req_ready; req_* fields are latched at that edge.
  - req_valid while busy is ignored; the requester holds it.
- States: IDLE, READ, CAPTURE, WRITE, DONE.
- IDLE, on accept:
  - Illegal or misaligned request: go to DONE with error.
  - SW: go to WRITE.
  - Any load, SB or SH: go to READ.
- READ: ram_address = aligned addr, ram_write_enable=0; next state CAPTURE.
- CAPTURE (ram_data_out valid):
  - Load: select lane by addr[1:0], extend into resp_rdata; next state DONE.
  - SB/SH: merge the new lane into ram_data_out, register it to ram_data_in; next state WRITE.
- WRITE: ram_write_enable=1 for exactly one cycle, with aligned address and full or merged word; next state DONE.
- DONE: resp_valid=1 for one cycle; resp_rdata/resp_error hold until the next DONE; next state IDLE.
- Latency, from the accept edge to the resp_valid cycle:
  - SW: 2 cycles (WRITE, DONE).
  - Loads: 3 cycles (READ, CAPTURE, DONE).
  - SB/SH: 4 cycles (READ, CAPTURE, WRITE, DONE).
  - Errors: 1 cycle.
- Extension rules:
  - LB: sign-extend bit 7 of the selected byte.
  - LBU: zero-extend the selected byte.
  - LH: sign-extend bit 15 of the selected half.
  - LHU: zero-extend the selected half.
  - LW: the word unchanged.
- Illegal funct3 (always resp_error=1, no RAM access):
  - Loads: 3, 6, 7.
  - Stores: 3 to 7.
- Back-to-back requests: a new request can be accepted in the cycle after DONE (IDLE).

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0:
  - resp_error=1 and no RAM access;
  - DONE follows the accept edge directly.
- Undefined:
  - the offset is truncated to natural alignment (half: addr[1] only; word: offset 0) and the access proceeds normally;
  - resp_error is asserted only for illegal funct3.

Decomposition:
- Shared package mem_pkg holds:
  - funct3 constants: F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5;
  - state encoding constants;
  - the RAM word-index slice width.
- One natural combinational sub-module, load_extend: inputs are the word, addr[1:0] and funct3; output is the 32-bit extended result. The RMW merge stays inline.

Test Plan:
- Reset, then SW addr 0x10 data 0xDEADBEEF: one-cycle write strobe, resp_valid 2 cycles after accept; LW 0x10 returns 0xDEADBEEF, resp_error=0, 3-cycle latency.
- Word 0x80FF7F01 at 0x20, then LB 0x20, LB 0x21, LBU 0x22, LH 0x22, LHU 0x22, returning in order:
  - 0x00000001;
  - 0x0000007F;
  - 0x000000FF;
  - 0xFFFF80FF;
  - 0x000080FF.
- Word 0x11223344 at 0x30, then SB 0x31 data 0xAA, then SH 0x32 data 0xBEEF: LW 0x30 returns 0xBEEFAA44; each store's ram_write_enable is high exactly one cycle.
- LW at 0x41:
  - with the macro: resp_error=1 after 1 cycle and ram_write_enable never high;
  - without it: reads word 0x40, resp_error=0.
- Load with funct3=3: resp_error=1, resp_rdata=0.
- Reset asserted in the READ state of an SB:
  - no RAM write occurs and no resp_valid;
  - req_ready=1 the next cycle;
  - the memory word is unchanged.
